// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: refill FSM
// states and the PC field-width helpers.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        REFILL = 2'd2,
        DONE   = 2'd3
    } icache_state_t;

    // PC is a byte address; the two lowest bits select a byte within a word.
    localparam int WORD_BYTE_BITS = 2;

    function automatic int offset_width_f(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int index_width_f(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int tag_width_f(input int address_width, input int line_words,
                                       input int num_lines);
        return address_width - WORD_BYTE_BITS - $clog2(line_words) - $clog2(num_lines);
    endfunction

endpackage

// File: rtl/instruction_cache_line_store.sv
// Tag, valid and data storage for the instruction cache. Reads are
// combinational; writes and valid updates happen on the clock edge.
module instruction_cache_line_store #(
    parameter int DATA_WIDTH   = 32,
    parameter int TAG_WIDTH    = 22,
    parameter int INDEX_WIDTH  = 6,
    parameter int OFFSET_WIDTH = 2
) (
    input  logic                    clk_i,
    input  logic                    srst_i,
    input  logic [INDEX_WIDTH-1:0]  rd_index_i,
    input  logic [OFFSET_WIDTH-1:0] rd_offset_i,
    output logic                    rd_valid_o,
    output logic [TAG_WIDTH-1:0]    rd_tag_o,
    output logic [DATA_WIDTH-1:0]   rd_data_o,
    input  logic                    wr_en_i,
    input  logic [INDEX_WIDTH-1:0]  wr_index_i,
    input  logic [OFFSET_WIDTH-1:0] wr_offset_i,
    input  logic [DATA_WIDTH-1:0]   wr_data_i,
    input  logic                    tag_wr_en_i,
    input  logic [TAG_WIDTH-1:0]    wr_tag_i,
    input  logic                    inv_en_i
);
    localparam int NUM_LINES  = 1 << INDEX_WIDTH;
    localparam int LINE_WORDS = 1 << OFFSET_WIDTH;

    logic [DATA_WIDTH-1:0] data_mem [NUM_LINES*LINE_WORDS];
    logic [TAG_WIDTH-1:0]  tag_mem  [NUM_LINES];
    logic [NUM_LINES-1:0]  valid_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            data_mem[{wr_index_i, wr_offset_i}] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (tag_wr_en_i) begin
            tag_mem[wr_index_i] <= wr_tag_i;
        end
    end

    // Only the valid bits are reset; stale tag/data are masked by valid.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            valid_q <= '0;
        end else if (tag_wr_en_i) begin
            valid_q[wr_index_i] <= 1'b1;
        end else if (inv_en_i) begin
            valid_q[wr_index_i] <= 1'b0;
        end
    end

    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_tag_o   = tag_mem[rd_index_i];
    assign rd_data_o  = data_mem[{rd_index_i, rd_offset_i}];

endmodule

// File: rtl/instruction_cache_direct_mapped.sv
// Direct-mapped L1 instruction cache with multi-word line refill from L2.
// Define INSTRUCTION_CACHE_PERF_EN to add HIT_COUNT/MISS_COUNT outputs.
module instruction_cache_direct_mapped
    import icache_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int L2_BUS_WIDTH  = 32,
    parameter int LINE_WORDS    = 4,
    parameter int NUM_LINES     = 64
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     STALL_INSTRUCTION_CACHE,
    input  logic [ADDRESS_WIDTH-1:0] PC,
    input  logic                     PC_VALID,
    output logic [DATA_WIDTH-1:0]    INSTRUCTION,
    output logic                     INSTRUCTION_VALID,
    output logic                     INSTRUCTION_CACHE_READY,
    input  logic                     ADDRESS_TO_L2_READY_INS,
    output logic                     ADDRESS_TO_L2_VALID_INS,
    output logic [ADDRESS_WIDTH-3:0] ADDRESS_TO_L2_INS,
    output logic                     DATA_FROM_L2_READY_INS,
    input  logic                     DATA_FROM_L2_VALID_INS,
    input  logic [L2_BUS_WIDTH-1:0]  DATA_FROM_L2_INS
`ifdef INSTRUCTION_CACHE_PERF_EN
    ,
    output logic [31:0]              HIT_COUNT,
    output logic [31:0]              MISS_COUNT
`endif
);
    localparam int OFFSET_WIDTH = offset_width_f(LINE_WORDS);
    localparam int INDEX_WIDTH  = index_width_f(NUM_LINES);
    localparam int TAG_WIDTH    = tag_width_f(ADDRESS_WIDTH, LINE_WORDS, NUM_LINES);
    localparam logic [OFFSET_WIDTH-1:0] LAST_BEAT = OFFSET_WIDTH'(LINE_WORDS - 1);

    icache_state_t            state_q, state_d;
    logic [TAG_WIDTH-1:0]     miss_tag_q, miss_tag_d;
    logic [INDEX_WIDTH-1:0]   miss_index_q, miss_index_d;
    logic [OFFSET_WIDTH-1:0]  miss_offset_q, miss_offset_d;
    logic [OFFSET_WIDTH-1:0]  count_q, count_d;
    logic [DATA_WIDTH-1:0]    instr_q, instr_d;
    logic                     instr_valid_q, instr_valid_d;

    logic [TAG_WIDTH-1:0]     pc_tag;
    logic [INDEX_WIDTH-1:0]   pc_index;
    logic [OFFSET_WIDTH-1:0]  pc_offset;
    logic                     rd_valid;
    logic [TAG_WIDTH-1:0]     rd_tag;
    logic [DATA_WIDTH-1:0]    rd_data;
    logic [DATA_WIDTH-1:0]    beat_word;
    logic                     lookup_hit;
    logic                     ready;
    logic                     accept;
    logic                     wr_en;
    logic                     tag_wr_en;
    logic                     inv_en;
    logic                     unused_pc_byte;

    assign pc_offset      = PC[WORD_BYTE_BITS +: OFFSET_WIDTH];
    assign pc_index       = PC[WORD_BYTE_BITS + OFFSET_WIDTH +: INDEX_WIDTH];
    assign pc_tag         = PC[ADDRESS_WIDTH-1 -: TAG_WIDTH];
    assign unused_pc_byte = ^PC[WORD_BYTE_BITS-1:0];
    assign beat_word      = DATA_FROM_L2_INS[DATA_WIDTH-1:0];

    instruction_cache_line_store #(
        .DATA_WIDTH   (DATA_WIDTH),
        .TAG_WIDTH    (TAG_WIDTH),
        .INDEX_WIDTH  (INDEX_WIDTH),
        .OFFSET_WIDTH (OFFSET_WIDTH)
    ) u_line_store (
        .clk_i       (CLK),
        .srst_i      (RST),
        .rd_index_i  (pc_index),
        .rd_offset_i (pc_offset),
        .rd_valid_o  (rd_valid),
        .rd_tag_o    (rd_tag),
        .rd_data_o   (rd_data),
        .wr_en_i     (wr_en),
        .wr_index_i  (miss_index_q),
        .wr_offset_i (count_q),
        .wr_data_i   (beat_word),
        .tag_wr_en_i (tag_wr_en),
        .wr_tag_i    (miss_tag_q),
        .inv_en_i    (inv_en)
    );

    assign lookup_hit = rd_valid && (rd_tag == pc_tag);
    assign ready      = (state_q == IDLE) || (state_q == DONE);
    assign accept     = PC_VALID && ready && !STALL_INSTRUCTION_CACHE;

    always_comb begin
        state_d       = state_q;
        miss_tag_d    = miss_tag_q;
        miss_index_d  = miss_index_q;
        miss_offset_d = miss_offset_q;
        count_d       = count_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        wr_en         = 1'b0;
        tag_wr_en     = 1'b0;
        inv_en        = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                // DONE behaves like IDLE except it cannot leave while stalled.
                if (!STALL_INSTRUCTION_CACHE) begin
                    state_d       = IDLE;
                    instr_valid_d = 1'b0;
                    if (PC_VALID) begin
                        if (lookup_hit) begin
                            instr_d       = rd_data;
                            instr_valid_d = 1'b1;
                        end else begin
                            miss_tag_d    = pc_tag;
                            miss_index_d  = pc_index;
                            miss_offset_d = pc_offset;
                            state_d       = REQ;
                        end
                    end
                end
            end
            REQ: begin
                if (ADDRESS_TO_L2_READY_INS) begin
                    inv_en  = 1'b1;
                    state_d = REFILL;
                end
            end
            REFILL: begin
                if (DATA_FROM_L2_VALID_INS) begin
                    wr_en   = 1'b1;
                    count_d = count_q + 1'b1;
                    if (count_q == miss_offset_q) begin
                        instr_d = beat_word;
                    end
                    if (count_q == LAST_BEAT) begin
                        tag_wr_en     = 1'b1;
                        instr_valid_d = 1'b1;
                        state_d       = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= IDLE;
            miss_tag_q    <= '0;
            miss_index_q  <= '0;
            miss_offset_q <= '0;
            count_q       <= '0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            miss_tag_q    <= miss_tag_d;
            miss_index_q  <= miss_index_d;
            miss_offset_q <= miss_offset_d;
            count_q       <= count_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign INSTRUCTION             = instr_q;
    assign INSTRUCTION_VALID       = instr_valid_q;
    assign INSTRUCTION_CACHE_READY = ready;
    assign ADDRESS_TO_L2_VALID_INS = (state_q == REQ);
    assign ADDRESS_TO_L2_INS       = {miss_tag_q, miss_index_q, {OFFSET_WIDTH{1'b0}}};
    assign DATA_FROM_L2_READY_INS  = (state_q == REFILL);

`ifdef INSTRUCTION_CACHE_PERF_EN
    logic [31:0] hit_count_q;
    logic [31:0] miss_count_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else if (accept) begin
            if (lookup_hit) begin
                hit_count_q <= hit_count_q + 32'd1;
            end else begin
                miss_count_q <= miss_count_q + 32'd1;
            end
        end
    end

    assign HIT_COUNT  = hit_count_q;
    assign MISS_COUNT = miss_count_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_instruction_cache_direct_mapped.sv
// Bench for instruction_cache_direct_mapped: directed scenarios followed by
// randomized fetches against a line-residency reference model.
module tb_instruction_cache_direct_mapped;

    logic        CLK = 1'b0;
    logic        RST;
    logic        STALL_INSTRUCTION_CACHE;
    logic [31:0] PC;
    logic        PC_VALID;
    logic [31:0] INSTRUCTION;
    logic        INSTRUCTION_VALID;
    logic        INSTRUCTION_CACHE_READY;
    logic        ADDRESS_TO_L2_READY_INS;
    logic        ADDRESS_TO_L2_VALID_INS;
    logic [29:0] ADDRESS_TO_L2_INS;
    logic        DATA_FROM_L2_READY_INS;
    logic        DATA_FROM_L2_VALID_INS;
    logic [31:0] DATA_FROM_L2_INS;
`ifdef INSTRUCTION_CACHE_PERF_EN
    logic [31:0] HIT_COUNT;
    logic [31:0] MISS_COUNT;
`endif

    instruction_cache_direct_mapped dut (
        .CLK                     (CLK),
        .RST                     (RST),
        .STALL_INSTRUCTION_CACHE (STALL_INSTRUCTION_CACHE),
        .PC                      (PC),
        .PC_VALID                (PC_VALID),
        .INSTRUCTION             (INSTRUCTION),
        .INSTRUCTION_VALID       (INSTRUCTION_VALID),
        .INSTRUCTION_CACHE_READY (INSTRUCTION_CACHE_READY),
        .ADDRESS_TO_L2_READY_INS (ADDRESS_TO_L2_READY_INS),
        .ADDRESS_TO_L2_VALID_INS (ADDRESS_TO_L2_VALID_INS),
        .ADDRESS_TO_L2_INS       (ADDRESS_TO_L2_INS),
        .DATA_FROM_L2_READY_INS  (DATA_FROM_L2_READY_INS),
        .DATA_FROM_L2_VALID_INS  (DATA_FROM_L2_VALID_INS),
        .DATA_FROM_L2_INS        (DATA_FROM_L2_INS)
`ifdef INSTRUCTION_CACHE_PERF_EN
        ,
        .HIT_COUNT               (HIT_COUNT),
        .MISS_COUNT              (MISS_COUNT)
`endif
    );

    always #5 CLK = ~CLK;

    int          n_total = 0;
    int          n_bad   = 0;
    bit          m_valid [64];
    logic [21:0] m_tag   [64];
    int          m_hits  = 0;
    int          m_misses = 0;
    logic [31:0] last_instr = 32'd0;
    bit          last_valid = 1'b0;

    // L2 contents: word address 0x40 holds 0xA0, each next word one more.
    function automatic logic [31:0] mem_word(input logic [29:0] w);
        return 32'hA0 + {2'b00, w} - 32'h40;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        STALL_INSTRUCTION_CACHE = 1'b0;
        PC = 32'd0;
        PC_VALID = 1'b0;
        ADDRESS_TO_L2_READY_INS = 1'b0;
        DATA_FROM_L2_VALID_INS = 1'b0;
        DATA_FROM_L2_INS = 32'd0;
        @(negedge CLK);
        check("rst_instr",  INSTRUCTION, 32'd0);
        check("rst_ivalid", 32'(INSTRUCTION_VALID), 32'd0);
        check("rst_ready",  32'(INSTRUCTION_CACHE_READY), 32'd1);
        check("rst_avalid", 32'(ADDRESS_TO_L2_VALID_INS), 32'd0);
        check("rst_addr",   32'(ADDRESS_TO_L2_INS), 32'd0);
        check("rst_dready", 32'(DATA_FROM_L2_READY_INS), 32'd0);
        RST = 1'b0;
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        m_hits = 0;
        m_misses = 0;
        last_instr = 32'd0;
        last_valid = 1'b0;
    endtask

    // One fetch of pc starting at a negedge; returns at a negedge with the
    // result visible. abort_after >= 0 resets the cache after that many beats.
    task automatic access(input logic [31:0] pc, input bit stall_refill, input int abort_after);
        logic [29:0] word;
        logic [29:0] line;
        int          idx;
        logic [21:0] tag;
        bit          hit;
        int          d;
        word = pc[31:2];
        line = {word[29:2], 2'b00};
        idx  = int'(pc[9:4]);
        tag  = pc[31:10];
        hit  = m_valid[idx] && (m_tag[idx] == tag);
        check("ready_in", 32'(INSTRUCTION_CACHE_READY), 32'd1);
        STALL_INSTRUCTION_CACHE = 1'b0;
        PC = pc;
        PC_VALID = 1'b1;
        @(negedge CLK);
        PC_VALID = 1'b0;
        PC = $urandom;
        if (hit) begin
            m_hits++;
            check("hit_valid", 32'(INSTRUCTION_VALID), 32'd1);
            check("hit_instr", INSTRUCTION, mem_word(word));
            check("hit_ready", 32'(INSTRUCTION_CACHE_READY), 32'd1);
            $display("fetch pc=%h hit  instr=%h", pc, INSTRUCTION);
            last_instr = mem_word(word);
            last_valid = 1'b1;
            return;
        end
        m_misses++;
        check("miss_valid", 32'(INSTRUCTION_VALID), 32'd0);
        check("miss_ready", 32'(INSTRUCTION_CACHE_READY), 32'd0);
        d = $urandom_range(0, 3);
        for (int i = 0; i < d; i++) begin
            DATA_FROM_L2_VALID_INS = 1'b1;
            DATA_FROM_L2_INS = $urandom;
            check("req_avalid", 32'(ADDRESS_TO_L2_VALID_INS), 32'd1);
            check("req_addr",   32'(ADDRESS_TO_L2_INS), 32'(line));
            check("req_dready", 32'(DATA_FROM_L2_READY_INS), 32'd0);
            @(negedge CLK);
        end
        DATA_FROM_L2_VALID_INS = 1'b0;
        ADDRESS_TO_L2_READY_INS = 1'b1;
        check("req_avalid", 32'(ADDRESS_TO_L2_VALID_INS), 32'd1);
        check("req_addr",   32'(ADDRESS_TO_L2_INS), 32'(line));
        @(negedge CLK);
        ADDRESS_TO_L2_READY_INS = 1'b0;
        check("refill_avalid", 32'(ADDRESS_TO_L2_VALID_INS), 32'd0);
        for (int b = 0; b < 4; b++) begin
            if (b == abort_after) begin
                $display("fetch pc=%h miss aborted by reset after %0d beats", pc, b);
                do_reset();
                return;
            end
            d = $urandom_range(0, 2);
            STALL_INSTRUCTION_CACHE = stall_refill;
            for (int i = 0; i < d; i++) begin
                check("refill_dready", 32'(DATA_FROM_L2_READY_INS), 32'd1);
                @(negedge CLK);
            end
            check("refill_dready", 32'(DATA_FROM_L2_READY_INS), 32'd1);
            check("refill_ivalid", 32'(INSTRUCTION_VALID), 32'd0);
            DATA_FROM_L2_VALID_INS = 1'b1;
            DATA_FROM_L2_INS = mem_word(line + 30'(b));
            @(negedge CLK);
            DATA_FROM_L2_VALID_INS = 1'b0;
        end
        m_valid[idx] = 1'b1;
        m_tag[idx] = tag;
        check("done_valid", 32'(INSTRUCTION_VALID), 32'd1);
        check("done_instr", INSTRUCTION, mem_word(word));
        check("done_ready", 32'(INSTRUCTION_CACHE_READY), 32'd1);
        $display("fetch pc=%h miss instr=%h stall=%0d", pc, INSTRUCTION, stall_refill);
        last_instr = mem_word(word);
        last_valid = 1'b1;
        if (stall_refill) begin
            PC_VALID = 1'b1;
            PC = $urandom;
            for (int i = 0; i < 2; i++) begin
                @(negedge CLK);
                check("stall_done_valid", 32'(INSTRUCTION_VALID), 32'd1);
                check("stall_done_instr", INSTRUCTION, last_instr);
            end
            STALL_INSTRUCTION_CACHE = 1'b0;
            PC_VALID = 1'b0;
            @(negedge CLK);
            check("unstall_valid", 32'(INSTRUCTION_VALID), 32'd0);
            last_valid = 1'b0;
        end
    endtask

    task automatic idle_cycle();
        STALL_INSTRUCTION_CACHE = 1'b0;
        PC_VALID = 1'b0;
        @(negedge CLK);
        check("idle_valid", 32'(INSTRUCTION_VALID), 32'd0);
        check("idle_instr", INSTRUCTION, last_instr);
        $display("idle cycle instr=%h", INSTRUCTION);
        last_valid = 1'b0;
    endtask

    task automatic stalled_cycle();
        STALL_INSTRUCTION_CACHE = 1'b1;
        PC_VALID = 1'b1;
        PC = $urandom;
        @(negedge CLK);
        check("stall_valid", 32'(INSTRUCTION_VALID), 32'(last_valid));
        check("stall_instr", INSTRUCTION, last_instr);
        $display("stalled cycle pc=%h ignored", PC);
        STALL_INSTRUCTION_CACHE = 1'b0;
        PC_VALID = 1'b0;
    endtask

    function automatic logic [31:0] rand_pc();
        int t;
        int i;
        int o;
        int lo;
        t  = $urandom_range(0, 3);
        i  = $urandom_range(0, 3);
        o  = $urandom_range(0, 3);
        lo = $urandom_range(0, 3);
        return 32'((t << 10) | (i << 4) | (o << 2) | lo);
    endfunction

    initial begin
        int r;
        do_reset();
        access(32'h108, 1'b0, -1);
        access(32'h100, 1'b0, -1);
        access(32'h104, 1'b0, -1);
        access(32'h10C, 1'b0, -1);
        access(32'h500, 1'b0, -1);
        access(32'h100, 1'b0, -1);
        access(32'h208, 1'b1, -1);
        stalled_cycle();
        idle_cycle();
        access(32'h300, 1'b0, 2);
        access(32'h304, 1'b0, -1);
`ifdef INSTRUCTION_CACHE_PERF_EN
        check("miss_count_after_rst", MISS_COUNT, 32'd1);
`endif
        for (int n = 0; n < 250; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0) idle_cycle();
            else if (r == 1) stalled_cycle();
            else access(rand_pc(), $urandom_range(0, 3) == 0, -1);
        end
`ifdef INSTRUCTION_CACHE_PERF_EN
        check("hit_count",  HIT_COUNT,  32'(m_hits));
        check("miss_count", MISS_COUNT, 32'(m_misses));
`endif
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/instruction_cache_direct_mapped.md
Name: instruction_cache_direct_mapped

Overview:
Parametrised direct-mapped L1 instruction cache with multi-word lines, sitting between the fetch stage (PC in, INSTRUCTION out) and the L2 cache. It replaces the pass-through fetch path with a real tag/valid lookup and a line-refill FSM. Misses drive the L2 address/data valid-ready channels; hits return in one cycle.

Parameters:
ADDRESS_WIDTH, 32, byte-address width of PC
DATA_WIDTH, 32, instruction width
L2_BUS_WIDTH, 32, L2 data beat width; must equal DATA_WIDTH (one word per beat)
LINE_WORDS, 4, words per line, power of two, ≥2
NUM_LINES, 64, number of lines, power of two, ≥2

Ports:
CLK  in  1  clock
RST  in  1  reset
STALL_INSTRUCTION_CACHE  in  1  hold outputs, accept no new PC
PC  in  ADDRESS_WIDTH  fetch byte address (bits [1:0] ignored)
PC_VALID  in  1  PC request valid
INSTRUCTION  out  DATA_WIDTH  fetched instruction
INSTRUCTION_VALID  out  1  INSTRUCTION holds data for the last accepted PC
INSTRUCTION_CACHE_READY  out  1  cache can accept a PC this cycle
ADDRESS_TO_L2_READY_INS  in  1  L2 accepts address
ADDRESS_TO_L2_VALID_INS  out  1  refill address valid
ADDRESS_TO_L2_INS  out  ADDRESS_WIDTH-2  line-aligned word address
DATA_FROM_L2_READY_INS  out  1  cache accepts a beat
DATA_FROM_L2_VALID_INS  in  1  beat valid
DATA_FROM_L2_INS  in  L2_BUS_WIDTH  refill beat

Behaviour:
- Clocking/reset: one clock, CLK; RST is synchronous, active-high.
- Address split: OFFSET = PC[2 +: log2(LINE_WORDS)], INDEX = next log2(NUM_LINES) bits, TAG = remaining upper bits.
- Reset values: INSTRUCTION=0, INSTRUCTION_VALID=0, INSTRUCTION_CACHE_READY=1, ADDRESS_TO_L2_VALID_INS=0, ADDRESS_TO_L2_INS=0, DATA_FROM_L2_READY_INS=0. All line valid bits cleared; FSM=IDLE; beat counter=0. Data/tag arrays are not reset.
- Accept: PC_VALID & READY & !STALL in cycle N. Tag compare is combinational on PC.
- Hit: INSTRUCTION and INSTRUCTION_VALID=1 registered in cycle N+1. READY stays 1, so back-to-back hits sustain one per cycle.
- Miss: in cycle N+1, INSTRUCTION_VALID=0, READY=0, and FSM enters REQ. The cache latches TAG, INDEX and OFFSET of the missing PC.
- FSM states:
  - IDLE: READY=1.
  - REQ: ADDRESS_TO_L2_VALID_INS=1 with ADDRESS_TO_L2_INS={TAG,INDEX,0s}, held stable until ADDRESS_TO_L2_READY_INS. The handshake cycle moves to REFILL.
  - REFILL: DATA_FROM_L2_READY_INS=1. Each valid beat writes data[INDEX][count] and count increments. The beat with count==latched OFFSET also loads INSTRUCTION. The beat with count==LINE_WORDS-1 sets tag, sets valid, and moves to DONE.
  - DONE (1 cycle): INSTRUCTION_VALID=1, READY=1, count=0, then IDLE.
- Miss latency: INSTRUCTION_VALID rises one cycle after the last beat.
- Beats are accepted only in REFILL. A valid beat in any other state is ignored.
- Line replacement: the refilled line overwrites the indexed line; its valid bit is cleared on entry to REFILL.
- STALL high: INSTRUCTION and INSTRUCTION_VALID are held and PC_VALID is ignored. REQ/REFILL continue, but the DONE→IDLE transition waits until STALL is low; outputs stay valid meanwhile.
- PC_VALID low while READY: INSTRUCTION_VALID=0 next cycle; INSTRUCTION holds its last value.
- RST mid-refill: returns to reset state the same edge; partially filled line stays invalid. L2 must be reset together with the cache.
- Index wrap: lines with equal INDEX and different TAG always miss and evict.

Optional Feature:
INSTRUCTION_CACHE_PERF_EN:
- Defined: adds outputs HIT_COUNT[31:0] and MISS_COUNT[31:0]. They increment on each accepted hit or miss, wrap at 2^32, and reset to 0 on RST.
- Undefined: those ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package icache_pkg: FSM state encoding (IDLE, REQ, REFILL, DONE); localparam helpers for OFFSET_WIDTH, INDEX_WIDTH, TAG_WIDTH derived via $clog2.
- One sub-module, instruction_cache_line_store: tag/valid/data arrays with combinational read, synchronous word write, synchronous valid clear on RST.

Test Plan:
- Reset then PC=0x100 valid with cold cache → READY=0 next cycle; ADDRESS_TO_L2_INS=0x40, valid held until L2 ready.
- L2 returns 4 beats 0xA0..0xA3 for PC=0x108 → INSTRUCTION=0xA2, INSTRUCTION_VALID=1 one cycle after 4th beat.
- After that refill, PCs 0x100,0x104,0x10C back-to-back → INSTRUCTION 0xA0,0xA1,0xA3 on consecutive cycles, READY constant 1.
- PC=0x100 then PC=0x500 (same index, NUM_LINES=64) → second is a miss; re-request of 0x100 misses again.
- STALL asserted during REFILL → beats still accepted; INSTRUCTION_VALID is held at DONE until STALL drops; new PC is ignored while stalled.
- RST asserted after 2 of 4 beats → outputs at reset values next cycle; the same PC then misses and refills fully (with PERF_EN: MISS_COUNT=1 after reset).
